// File: rtl/lisp_defs.sv
// Shared display types and glyph constants for the seven-segment driver.
// Glyphs are active-low with bit 7 as the decimal point.
package lisp_defs;

    typedef enum logic [1:0] {
        MODE_BLANK = 2'd0,
        MODE_VALUE = 2'd1,
        MODE_ERROR = 2'd2,
        MODE_BUSY  = 2'd3
    } display_mode_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;

    localparam int         NUM_DIGITS = 4;
    localparam logic [2:0] BUSY_LAST  = 3'd5;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low a..g segment decoder (bit 0 = a).
module hex_to_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg_display.sv
// Multiplexed 4-digit seven-segment driver showing a value, an error code,
// or a busy animation; outputs only update on a digit-slot wrap or a load.
module seg_display
    import lisp_defs::*;
#(
    parameter int RefreshDiv = 100000,
    parameter int AnimFrames = 50
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  display_mode_t mode,
    input  logic [15:0]   value,
    output logic [7:0]    cathodes,
    output logic [3:0]    anodes
);

    localparam int            PW        = $clog2(RefreshDiv);
    localparam logic [PW-1:0] PRE_MAX   = PW'(RefreshDiv - 1);
    localparam logic [7:0]    FRAME_MAX = 8'(AnimFrames - 1);

    display_mode_t mode_q, mode_d;
    logic [15:0]   value_q, value_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [1:0]    digit_q, digit_d;
    logic [7:0]    frame_q, frame_d;
    logic [2:0]    anim_q, anim_d;
    logic [7:0]    cathodes_q, cathodes_d;
    logic [3:0]    anodes_q, anodes_d;

    logic          wrap;
    logic [3:0]    nibble;
    logic [6:0]    hex_seg;

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        mode_d      = mode_q;
        value_d     = value_q;
        frame_d     = frame_q;
        anim_d      = anim_q;
        anodes_d    = anodes_q;
        cathodes_d  = cathodes_q;

        if (load) begin
            mode_d  = mode;
            value_d = value;
        end

        wrap        = (prescaler_q == PRE_MAX);
        prescaler_d = wrap ? '0 : prescaler_q + 1'b1;
        digit_d     = wrap ? digit_q + 2'd1 : digit_q;

        // A busy step completes after AnimFrames full scans, counted at the 3->0 wrap.
        if (load && mode == MODE_BUSY) begin
            frame_d = '0;
            anim_d  = '0;
        end else if (wrap && digit_q == 2'd3) begin
            if (frame_q == FRAME_MAX) begin
                frame_d = '0;
                anim_d  = (anim_q == BUSY_LAST) ? 3'd0 : anim_q + 3'd1;
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end

        nibble = value_d[{digit_d, 2'b00} +: 4];

        // Render from next-state values so a load on a wrap shows on the new digit.
        if (wrap || load) begin
            anodes_d = ~(4'b0001 << digit_d);
            unique case (mode_d)
                MODE_BLANK: begin
                    anodes_d   = 4'b1111;
                    cathodes_d = SEG_BLANK;
                end
                MODE_VALUE: cathodes_d = {~(digit_d == 2'd3 && value_d[15]), hex_seg};
                MODE_ERROR: begin
                    if (digit_d == 2'd3)      cathodes_d = SEG_E;
                    else if (digit_d == 2'd2) cathodes_d = SEG_R;
                    else                      cathodes_d = {1'b1, hex_seg};
                end
                default:    cathodes_d = {1'b1, ~(7'd1 << anim_d)};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_BLANK;
            value_q     <= '0;
            prescaler_q <= '0;
            digit_q     <= '0;
            frame_q     <= '0;
            anim_q      <= '0;
            anodes_q    <= 4'b1111;
            cathodes_q  <= SEG_BLANK;
        end else begin
            mode_q      <= mode_d;
            value_q     <= value_d;
            prescaler_q <= prescaler_d;
            digit_q     <= digit_d;
            frame_q     <= frame_d;
            anim_q      <= anim_d;
            anodes_q    <= anodes_d;
            cathodes_q  <= cathodes_d;
        end
    end

    assign anodes   = anodes_q;
    assign cathodes = cathodes_q;

endmodule
